// File: rtl/tri_state_bus_arbiter_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   state_e     : arbiter FSM states
//   clog2_min1  : index width that never collapses to zero bits
package tri_state_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  // Width of an index able to address n items; at least 1 bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tri_state_bus_arbiter_if.sv
// Bundle of request/grant/bus signals between local masters and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: masters hold req as a level until granted; no other stall path.
//   en, req, data        : master -> arbiter
//   gnt, oe, owner, busy : arbiter -> master
//   bus                  : shared tri-state net driven by the arbiter
interface tri_state_bus_arbiter_if
  import tri_state_bus_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = clog2_min1(N);

  logic              en;
  logic [N-1:0]      req;
  logic [N*W-1:0]    data;
  logic [N-1:0]      gnt;
  logic [N-1:0]      oe;
  logic [IW-1:0]     owner;
  logic              busy;
  wire  [W-1:0]      bus;

  modport master (
    output en, req, data,
    input  gnt, oe, owner, busy, bus
  );

  modport slave (
    input  en, req, data,
    output gnt, oe, owner, busy, bus
  );

endinterface

// File: rtl/tri_state_bus_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; any is low when nothing is requesting.
//   req      : request vector
//   ptr      : highest-priority index this round
//   pick     : one-hot winner
//   pick_idx : binary index of the winner
//   any      : at least one request present
module rr_arbiter
  import tri_state_bus_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx,
  output logic          any
);

  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    // Scan N positions starting at ptr; the first hit wins.
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/tri_state_bus_arbiter.sv
// Round-robin owner selection for one shared W-bit tri-state bus, with burst cap and turnaround gap.
// Latency: 1 cycle req->gnt from IDLE; next grant no earlier than TURN_CYC+1 cycles after a release.
// Backpressure: requests are levels; those arriving in TURN or with en low simply wait.
//   clk, rst_n : clock and synchronous active-low reset
//   bif        : slave side of tri_state_bus_arbiter_if (en/req/data in; gnt/oe/owner/busy/bus out)
// Optional macro BUS_KEEPER_EN: bus holds the last driven value instead of floating when idle.
module tri_state_bus_arbiter
  import tri_state_bus_arbiter_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4,
  parameter int TURN_CYC  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tri_state_bus_arbiter_if.slave   bif
);

  localparam int IW = clog2_min1(N);
  localparam int BW = clog2_min1((MAX_BURST > 2) ? MAX_BURST : 2);
  localparam int TW = clog2_min1((TURN_CYC > 2) ? TURN_CYC : 2);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] turn_q, turn_d;

  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic          any;
  logic          burst_limit;
  logic          rel;
  logic [W-1:0]  data_sel;

  rr_arbiter #(.N(N)) u_rr (
    .req      (bif.req),
    .ptr      (rr_ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  // With MAX_BURST == 0 the counter just wraps and never forces a release.
  assign burst_limit = (MAX_BURST != 0) && (burst_q == BW'(MAX_BURST - 1));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    turn_d   = turn_q;
    rel      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bif.en && any) begin
          gnt_d   = pick;
          owner_d = pick_idx;
          burst_d = '0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        rel = !bif.req[owner_q] || !bif.en || burst_limit;
        if (rel) begin
          gnt_d    = '0;
          // Previous owner drops to lowest priority for the next round.
          rr_ptr_d = IW'((int'(owner_q) + 1) % N);
          turn_d   = TW'(TURN_CYC - 1);
          state_d  = ST_TURN;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
      ST_TURN: begin
        if (turn_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset wins immediately, even mid-DRIVE: oe drops on the same edge with no turnaround.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      turn_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      turn_q   <= turn_d;
    end
  end

  assign bif.gnt   = gnt_q;
  assign bif.oe    = gnt_q;
  assign bif.owner = owner_q;
  assign bif.busy  = (state_q != ST_IDLE);

  assign data_sel = bif.data[int'(owner_q)*W +: W];

`ifdef BUS_KEEPER_EN
  logic [W-1:0] keep_q;

  // Track what the owner put on the bus so idle cycles repeat it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keep_q <= '0;
    end else if (|gnt_q) begin
      keep_q <= data_sel;
    end
  end

  assign bif.bus = (|gnt_q) ? data_sel : keep_q;
`else
  assign bif.bus = (|gnt_q) ? data_sel : {W{1'bz}};
`endif

endmodule

// File: tb/tb_tri_state_bus_arbiter.sv
// Directed bench for tri_state_bus_arbiter (N=4, W=8, MAX_BURST=4, TURN_CYC=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_tri_state_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] dat [4];
  int         seq [5];

  tri_state_bus_arbiter_if #(.N(4), .W(8)) bif ();

  tri_state_bus_arbiter #(
    .N(4), .W(8), .MAX_BURST(4), .TURN_CYC(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Granted cycle: gnt, oe, owner, busy, bus, and one-hot oe.
  task automatic chk_owned(input string tag, input int ch);
    chk({tag, "_gnt"},   32'(bif.gnt), 32'(1) << ch);
    chk({tag, "_oe"},    32'(bif.oe),  32'(1) << ch);
    chk({tag, "_owner"}, 32'(bif.owner), 32'(ch));
    chk({tag, "_busy"},  32'(bif.busy), 32'd1);
    chk({tag, "_bus"},   32'(bif.bus), 32'(dat[ch]));
    chk({tag, "_1hot"},  32'($onehot0(bif.oe)), 32'd1);
  endtask

  task automatic chk_free(input string tag, input logic exp_busy);
    chk({tag, "_gnt"},  32'(bif.gnt), 32'd0);
    chk({tag, "_oe"},   32'(bif.oe),  32'd0);
    chk({tag, "_busy"}, 32'(bif.busy), 32'(exp_busy));
  endtask

  initial begin
    dat[0] = 8'h11; dat[1] = 8'hA5; dat[2] = 8'h3C; dat[3] = 8'hD4;
    seq[0] = 2; seq[1] = 3; seq[2] = 0; seq[3] = 1; seq[4] = 2;

    rst_n    = 1'b0;
    bif.en   = 1'b0;
    bif.req  = 4'b0000;
    bif.data = {dat[3], dat[2], dat[1], dat[0]};
    tick();
    tick();
    chk_free("reset", 1'b0);
    chk("reset_owner", 32'(bif.owner), 32'd0);

    rst_n = 1'b1;
    tick();
    chk_free("post_reset", 1'b0);

    // Single request on ch1: nothing before the edge, granted at the edge.
    bif.en  = 1'b1;
    bif.req = 4'b0010;
    #1;
    chk("single_pre_gnt", 32'(bif.gnt), 32'd0);
    tick();
    chk_owned("single", 1);
    bif.req = 4'b0000;
    tick();
    chk_free("single_turn", 1'b1);
    tick();
    chk_free("single_idle", 1'b0);

    // All requesting; rr_ptr is 2 after ch1 released. Each owner holds 4 cycles, then TURN + IDLE.
    bif.req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk_owned("rr", seq[r]);
      end
      tick();
      chk_free("rr_turn", 1'b1);
      tick();
      chk_free("rr_idle", 1'b0);
    end

    // rr_ptr is 3 now: ch3 wins over ch0, then ch0 gets the next round.
    bif.req = 4'b1001;
    tick();
    chk_owned("wrap_ch3", 3);
    for (int c = 0; c < 3; c++) tick();
    chk_owned("wrap_ch3_last", 3);
    tick();
    chk_free("wrap_turn", 1'b1);
    tick();
    chk_free("wrap_idle", 1'b0);
    tick();
    chk_owned("wrap_ch0", 0);

    // en drop mid-DRIVE releases at the next edge and blocks new grants.
    bif.en = 1'b0;
    #1;
    chk("en_pre_gnt", 32'(bif.gnt), 32'b0001);
    tick();
    chk_free("en_turn", 1'b1);
    tick();
    chk_free("en_idle", 1'b0);
    tick();
    chk_free("en_hold", 1'b0);
    // rr_ptr is 1, requests {0,3}: ch3 is next.
    bif.en = 1'b1;
    tick();
    chk_owned("en_regrant", 3);

    // Reset pulse between edges is ignored.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk_owned("glitch", 3);

    // Reset at an edge mid-DRIVE: grant drops immediately, straight to IDLE.
    rst_n = 1'b0;
    tick();
    chk_free("rst_drive", 1'b0);
    chk("rst_owner", 32'(bif.owner), 32'd0);

    // After reset rr_ptr is 0; ch2 alone is granted.
    rst_n   = 1'b1;
    bif.req = 4'b0100;
    tick();
    chk_owned("post_rst", 2);
    bif.req = 4'b0000;
    tick();
    chk_free("post_rst_turn", 1'b1);
`ifdef BUS_KEEPER_EN
    chk("keep_turn", 32'(bif.bus), 32'h3C);
    tick();
    chk("keep_idle", 32'(bif.bus), 32'h3C);
    rst_n = 1'b0;
    tick();
    chk("keep_rst", 32'(bif.bus), 32'h00);
    rst_n = 1'b1;
`else
    tick();
    chk_free("post_rst_idle", 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
